// File: rtl/ipv4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_pkg
// Purpose  : Shared IPv4 definitions for the TX framer and the RX parser.
//            Holds the framer state encoding, fixed header constants, the
//            default payload limit, the latched header field record and
//            helpers that flatten it into network byte order.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ipv4_pkg;

  localparam int OCT              = 8;
  localparam int IPV4_MAX_PAYLOAD = 1480;
  localparam int IPV4_HDR_LEN     = 20;
  localparam int IPV4_HDR_WORDS   = 10;

  localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
  localparam logic [15:0] IPV4_FLAGS_DF = 16'h4000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CSUM    = 2'd1,
    ST_HEADER  = 2'd2,
    ST_PAYLOAD = 2'd3
  } ipv4_state_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  protocol;
    logic [7:0]  ttl;
    logic [15:0] id;
    logic [15:0] payload_len;
    logic [15:0] total_len;
  } ipv4_hdr_t;

  // Whole 20-byte header, byte 0 in the top bits.
  function automatic logic [159:0] hdr_vec(input ipv4_hdr_t h, input logic [15:0] csum);
    return {IPV4_VER_IHL, 8'h00, h.total_len, h.id, IPV4_FLAGS_DF,
            h.ttl, h.protocol, csum, h.src_ip, h.dst_ip};
  endfunction

  // 16-bit header word idx (0..9) with the checksum field taken as zero.
  function automatic logic [15:0] hdr_word(input ipv4_hdr_t h, input logic [3:0] idx);
    logic [159:0] v;
    v = hdr_vec(h, 16'h0000) << {idx, 4'b0000};
    return v[159:144];
  endfunction

  // Header byte idx (0..19) including the computed checksum.
  function automatic logic [7:0] hdr_byte(input ipv4_hdr_t h, input logic [15:0] csum,
                                          input logic [4:0] idx);
    logic [159:0] v;
    v = hdr_vec(h, csum) << {idx, 3'b000};
    return v[159:152];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipv4_csum.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_csum
// Purpose  : One's-complement 16-bit word accumulator. Words are summed into
//            a 20-bit accumulator (room for the carries of 16 words); fold
//            wraps the carries back twice and stores the inverted result.
// Ports    : clk, rst_n   clock / async active-low reset
//            clr          zero the accumulator
//            add, word    add one 16-bit word
//            fold         register ~fold(acc) into csum
//            csum         resulting checksum
// Revision : 1.0 - initial release
// ============================================================================
module ipv4_csum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add,
  input  logic        fold,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc;
  logic [16:0] sum1;
  logic [16:0] sum2;

  // Two folds: the first can itself carry out once, the second cannot.
  always_comb begin
    sum1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    sum2 = {1'b0, sum1[15:0]} + {16'd0, sum1[16]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= 20'd0;
      csum <= 16'd0;
    end else begin
      if (clr)
        acc <= 20'd0;
      else if (add)
        acc <= acc + {4'd0, word};
      if (fold)
        csum <= ~sum2[15:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_ipv4.sv
`default_nettype none
// ============================================================================
// Module   : tx_ipv4
// Purpose  : Transmit-side IPv4 framer. Latches header fields on tx_start,
//            computes the header checksum, emits the 20-byte header and then
//            passes the payload through as one octet stream.
// Ports    : TX_CLK, rst_n         clock / async active-low reset
//            tx_start + fields     request and header fields (sampled together)
//            tx_busy/err/done      status
//            tx_data_*             upstream payload (valid/ready)
//            tx_payload*           downstream octet stream (valid/ready)
// Revision : 1.0 - initial release
// ============================================================================
module tx_ipv4
  import ipv4_pkg::*;
#(
  parameter int MAX_PAYLOAD = IPV4_MAX_PAYLOAD
) (
  input  logic           TX_CLK,
  input  logic           rst_n,
  input  logic           tx_start,
  input  logic [31:0]    tx_src_ip,
  input  logic [31:0]    tx_dst_ip,
  input  logic [7:0]     tx_protocol,
  input  logic [7:0]     tx_ttl,
  input  logic [15:0]    tx_id,
  input  logic [15:0]    tx_payload_len,
  output logic           tx_busy,
  output logic           tx_err,
  output logic           tx_done,
  input  logic [OCT-1:0] tx_data_in,
  input  logic           tx_data_valid,
  output logic           tx_data_ready,
  output logic           tx_payload_ipv4,
  output logic [OCT-1:0] tx_payload,
  input  logic           tx_payload_ready
);

  ipv4_state_t     state;
  ipv4_hdr_t       hdr;
  logic [15:0]     cnt;        // csum word index, then header byte, then payload count
  logic [15:0]     csum;
  logic            hdr_valid;
  logic [OCT-1:0]  hdr_data;

  logic            accept;
  logic            csum_add;
  logic            csum_fold;
  logic [15:0]     csum_word;

  assign accept    = (state == ST_IDLE) && tx_start && (tx_payload_len <= 16'(MAX_PAYLOAD));
  assign csum_add  = (state == ST_CSUM) && (cnt <  16'(IPV4_HDR_WORDS));
  assign csum_fold = (state == ST_CSUM) && (cnt == 16'(IPV4_HDR_WORDS));
  assign csum_word = hdr_word(hdr, cnt[3:0]);

  ipv4_csum u_csum (
    .clk   (TX_CLK),
    .rst_n (rst_n),
    .clr   (accept),
    .add   (csum_add),
    .fold  (csum_fold),
    .word  (csum_word),
    .csum  (csum)
  );

  // Payload is a straight pass-through; header bytes come from registers.
  assign tx_payload_ipv4 = (state == ST_PAYLOAD) ? tx_data_valid : hdr_valid;
  assign tx_payload      = (state == ST_PAYLOAD) ? tx_data_in    : hdr_data;
  assign tx_data_ready   = (state == ST_PAYLOAD) && tx_payload_ready;

  always_ff @(posedge TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hdr       <= '0;
      cnt       <= 16'd0;
      tx_busy   <= 1'b0;
      tx_err    <= 1'b0;
      tx_done   <= 1'b0;
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
    end else begin
      tx_err  <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            if (accept) begin
              hdr.src_ip      <= tx_src_ip;
              hdr.dst_ip      <= tx_dst_ip;
              hdr.protocol    <= tx_protocol;
              hdr.ttl         <= tx_ttl;
              hdr.id          <= tx_id;
              hdr.payload_len <= tx_payload_len;
              hdr.total_len   <= tx_payload_len + 16'(IPV4_HDR_LEN);
              cnt             <= 16'd0;
              tx_busy         <= 1'b1;
              state           <= ST_CSUM;
            end else begin
              tx_err <= 1'b1;
            end
          end
        end

        ST_CSUM: begin
          if (cnt < 16'(IPV4_HDR_WORDS)) begin
            cnt <= cnt + 16'd1;
          end else begin
            // Fold happens on this edge; byte 0 is constant so it can go now.
            cnt       <= 16'd0;
            hdr_valid <= 1'b1;
            hdr_data  <= IPV4_VER_IHL;
            state     <= ST_HEADER;
          end
        end

        ST_HEADER: begin
          if (tx_payload_ready) begin
            if (cnt == 16'(IPV4_HDR_LEN - 1)) begin
              hdr_valid <= 1'b0;
              hdr_data  <= '0;
              cnt       <= 16'd0;
              if (hdr.payload_len == 16'd0) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
                state   <= ST_IDLE;
              end else begin
                state <= ST_PAYLOAD;
              end
            end else begin
              cnt      <= cnt + 16'd1;
              hdr_data <= hdr_byte(hdr, csum, 5'(cnt + 16'd1));
            end
          end
        end

        ST_PAYLOAD: begin
          if (tx_data_valid && tx_payload_ready) begin
            if (cnt + 16'd1 == hdr.payload_len) begin
              cnt     <= 16'd0;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_ipv4.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_ipv4
// Purpose  : Self-checking bench for tx_ipv4 with a byte-queue reference
//            model (header built from field arithmetic, checksum from a plain
//            one's-complement sum loop, payload copied from the source array).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_ipv4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_start;
  logic [31:0] tx_src_ip, tx_dst_ip;
  logic [7:0]  tx_protocol, tx_ttl;
  logic [15:0] tx_id, tx_payload_len;
  logic        tx_busy, tx_err, tx_done;
  logic [7:0]  tx_data_in;
  logic        tx_data_valid, tx_data_ready;
  logic        tx_payload_ipv4;
  logic [7:0]  tx_payload;
  logic        tx_payload_ready;

  always #5 clk = ~clk;

  tx_ipv4 dut (
    .TX_CLK           (clk),
    .rst_n            (rst_n),
    .tx_start         (tx_start),
    .tx_src_ip        (tx_src_ip),
    .tx_dst_ip        (tx_dst_ip),
    .tx_protocol      (tx_protocol),
    .tx_ttl           (tx_ttl),
    .tx_id            (tx_id),
    .tx_payload_len   (tx_payload_len),
    .tx_busy          (tx_busy),
    .tx_err           (tx_err),
    .tx_done          (tx_done),
    .tx_data_in       (tx_data_in),
    .tx_data_valid    (tx_data_valid),
    .tx_data_ready    (tx_data_ready),
    .tx_payload_ipv4  (tx_payload_ipv4),
    .tx_payload       (tx_payload),
    .tx_payload_ready (tx_payload_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] pay [0:1535];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int  src_idx, consumed, dr_cnt, done_cnt, err_cnt, busy_cnt, stall_err;
  bit  prev_stall;
  logic [7:0] prev_data;
  bit  rand_ready = 1'b0;
  bit  rand_valid = 1'b0;

  // ---------------- reference model ----------------
  task automatic build_expected(input logic [31:0] src, input logic [31:0] dst,
                                input logic [7:0] proto, input logic [7:0] ttl,
                                input logic [15:0] id, input logic [15:0] len);
    int unsigned w [10];
    int unsigned sum;
    logic [15:0] total, ck;
    total = len + 16'd20;
    w[0] = 32'h4500;          w[1] = {16'd0, total};
    w[2] = {16'd0, id};       w[3] = 32'h4000;
    w[4] = {16'd0, ttl, proto}; w[5] = 32'd0;
    w[6] = {16'd0, src[31:16]}; w[7] = {16'd0, src[15:0]};
    w[8] = {16'd0, dst[31:16]}; w[9] = {16'd0, dst[15:0]};
    sum = 0;
    for (int i = 0; i < 10; i++) sum += w[i];
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0];
    exp_q.delete();
    exp_q.push_back(8'h45); exp_q.push_back(8'h00);
    exp_q.push_back(total[15:8]); exp_q.push_back(total[7:0]);
    exp_q.push_back(id[15:8]); exp_q.push_back(id[7:0]);
    exp_q.push_back(8'h40); exp_q.push_back(8'h00);
    exp_q.push_back(ttl); exp_q.push_back(proto);
    exp_q.push_back(ck[15:8]); exp_q.push_back(ck[7:0]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(src[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(dst[i*8 +: 8]);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(pay[i]);
  endtask

  // ---------------- cycle driver / monitor ----------------
  task automatic tick();
    bit xfer_in;
    @(negedge clk);
    if (tx_payload_ipv4 && tx_payload_ready) got_q.push_back(tx_payload);
    xfer_in = tx_data_valid && tx_data_ready;
    if (xfer_in) consumed++;
    if (tx_data_ready) dr_cnt++;
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_busy) busy_cnt++;
    if (prev_stall && !(tx_payload_ipv4 && tx_payload == prev_data)) stall_err++;
    prev_stall = tx_payload_ipv4 && !tx_payload_ready && (got_q.size() < 20);
    prev_data  = tx_payload;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    if (xfer_in && src_idx < 1535) src_idx++;
    tx_payload_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    tx_data_valid    = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    tx_data_in       = pay[src_idx];
  endtask

  task automatic new_frame();
    for (int i = 0; i < 1536; i++) pay[i] = 8'($urandom);
    src_idx = 0; consumed = 0; dr_cnt = 0; done_cnt = 0; err_cnt = 0;
    busy_cnt = 0; stall_err = 0; prev_stall = 1'b0;
    got_q.delete();
    tx_data_in = pay[0];
  endtask

  task automatic start_frame(input logic [31:0] src, input logic [31:0] dst,
                             input logic [7:0] proto, input logic [7:0] ttl,
                             input logic [15:0] id, input logic [15:0] len);
    tx_src_ip = src; tx_dst_ip = dst; tx_protocol = proto; tx_ttl = ttl;
    tx_id = id; tx_payload_len = len;
    build_expected(src, dst, proto, ttl, id, len);
    tx_start = 1'b1;
    tick();
  endtask

  task automatic wait_done(output int n, output bit timeout);
    n = 0; timeout = 1'b0;
    while (!tx_done) begin
      if (n >= 8000) begin timeout = 1'b1; break; end
      tick();
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; tx_start = 1'b0; tx_payload_ready = 1'b1; tx_data_valid = 1'b1;
    tx_src_ip = '0; tx_dst_ip = '0; tx_protocol = '0; tx_ttl = '0; tx_id = '0;
    tx_payload_len = '0;
    new_frame();
    tick(); tick();
    checks++;
    if ({tx_busy, tx_err, tx_done, tx_data_ready, tx_payload_ipv4} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000",
                         {tx_busy, tx_err, tx_done, tx_data_ready, tx_payload_ipv4});
    end
    checks++;
    if (tx_payload !== 8'h00) begin
      errors++; $display("FAIL reset_payload: got %h required 00", tx_payload);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (tx_busy !== 1'b0 || tx_data_ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy %b data_ready %b required 0 0",
                         tx_busy, tx_data_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] ref_hdr [20];
    int k, n, mism;
    bit to;
    ref_hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    rand_ready = 1'b0; rand_valid = 1'b0;
    new_frame();
    start_frame(32'hC0A8_0001, 32'hC0A8_00C7, 8'h11, 8'h40, 16'h0000, 16'd95);
    checks++;
    if (tx_busy !== 1'b1 || tx_payload_ipv4 !== 1'b0) begin
      errors++; $display("FAIL basic_accept: busy %b valid %b required 1 0", tx_busy, tx_payload_ipv4);
    end
    k = 0;
    while (!tx_payload_ipv4 && k < 50) begin tick(); k++; end
    checks++;
    if (k != 11 || tx_payload !== 8'h45) begin
      errors++; $display("FAIL basic_latency: %0d edges byte %h required 11 edges byte 45", k, tx_payload);
    end
    wait_done(n, to);
    checks++;
    if (to || k + n != 126) begin
      errors++; $display("FAIL basic_done_edge: done after %0d edges (timeout %0d) required 126", k + n, to);
    end
    tick(); tick(); tick();
    mism = 0;
    for (int i = 0; i < 20 && i < got_q.size(); i++) if (got_q[i] !== ref_hdr[i]) mism++;
    checks++;
    if (got_q.size() < 20 || mism != 0) begin
      errors++; $display("FAIL basic_header: %0d bytes %0d wrong of required header", got_q.size(), mism);
    end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (got_q.size() != exp_q.size() || mism != 0) begin
      errors++; $display("FAIL basic_frame: %0d bytes %0d wrong required %0d bytes", got_q.size(), mism, exp_q.size());
    end
    checks++;
    if (done_cnt != 1 || consumed != 95 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL basic_status: done %0d consumed %0d busy %b required 1 95 0", done_cnt, consumed, tx_busy);
    end
  endtask

  task automatic test_backpressure();
    int n, mism;
    bit to;
    rand_ready = 1'b1; rand_valid = 1'b1;
    new_frame();
    start_frame(32'hC0A8_0001, 32'hC0A8_00C7, 8'h11, 8'h40, 16'h0000, 16'd95);
    wait_done(n, to);
    tick(); tick(); tick();
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || got_q.size() != exp_q.size() || mism != 0) begin
      errors++; $display("FAIL bp_frame: %0d bytes %0d wrong timeout %0d required %0d bytes", got_q.size(), mism, to, exp_q.size());
    end
    checks++;
    if (stall_err != 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable stall cycles required 0", stall_err);
    end
    checks++;
    if (done_cnt != 1 || consumed != 95) begin
      errors++; $display("FAIL bp_status: done %0d consumed %0d required 1 95", done_cnt, consumed);
    end
  endtask

  task automatic test_len0();
    int n, mism;
    bit to;
    rand_ready = 1'b1; rand_valid = 1'b0;
    new_frame();
    start_frame(32'h0A00_0001, 32'h0A00_0002, 8'h11, 8'h80, 16'h1234, 16'd0);
    wait_done(n, to);
    tick(); tick(); tick();
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || got_q.size() != 20 || mism != 0) begin
      errors++; $display("FAIL len0_frame: %0d bytes %0d wrong required 20 bytes", got_q.size(), mism);
    end
    checks++;
    if (got_q.size() < 4 || {got_q[2], got_q[3]} !== 16'h0014) begin
      errors++; $display("FAIL len0_total: total length wrong, required 0014");
    end
    checks++;
    if (dr_cnt != 0 || done_cnt != 1) begin
      errors++; $display("FAIL len0_status: data_ready cycles %0d done %0d required 0 1", dr_cnt, done_cnt);
    end
  endtask

  task automatic test_limits();
    int n, mism;
    bit to;
    rand_ready = 1'b0; rand_valid = 1'b0;
    new_frame();
    start_frame(32'h0101_0101, 32'h0202_0202, 8'h11, 8'h40, 16'h0001, 16'd1481);
    checks++;
    if (tx_err !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL err_pulse: err %b busy %b required 1 0", tx_err, tx_busy);
    end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (err_cnt != 1 || busy_cnt != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL err_quiet: err %0d busy %0d bytes %0d required 1 0 0", err_cnt, busy_cnt, got_q.size());
    end
    rand_ready = 1'b1; rand_valid = 1'b1;
    new_frame();
    start_frame(32'h0101_0101, 32'h0202_0202, 8'h11, 8'h40, 16'h0002, 16'd1480);
    wait_done(n, to);
    tick(); tick();
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || got_q.size() != 1500 || mism != 0 || err_cnt != 0) begin
      errors++; $display("FAIL max_frame: %0d bytes %0d wrong err %0d required 1500 bytes", got_q.size(), mism, err_cnt);
    end
    checks++;
    if (got_q.size() < 4 || {got_q[2], got_q[3]} !== 16'h05DC) begin
      errors++; $display("FAIL max_total: total length wrong, required 05DC");
    end
  endtask

  task automatic test_start_in_payload();
    int n, mism, k;
    bit to;
    rand_ready = 1'b0; rand_valid = 1'b1;
    new_frame();
    start_frame(32'hAC10_0005, 32'hAC10_0009, 8'h06, 8'h20, 16'hBEEF, 16'd40);
    k = 0;
    while (got_q.size() < 30 && k < 500) begin tick(); k++; end
    tx_src_ip = 32'hFFFF_FFFF; tx_payload_len = 16'd5; tx_start = 1'b1;
    tick();
    wait_done(n, to);
    for (int i = 0; i < 15; i++) tick();
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || got_q.size() != exp_q.size() || mism != 0) begin
      errors++; $display("FAIL midstart_frame: %0d bytes %0d wrong required %0d bytes", got_q.size(), mism, exp_q.size());
    end
    checks++;
    if (done_cnt != 1 || tx_busy !== 1'b0 || consumed != 40) begin
      errors++; $display("FAIL midstart_status: done %0d busy %b consumed %0d required 1 0 40", done_cnt, tx_busy, consumed);
    end
  endtask

  task automatic test_back_to_back();
    int n, mism;
    bit to;
    rand_ready = 1'b0; rand_valid = 1'b0;
    new_frame();
    start_frame(32'h0A0A_0A0A, 32'h0B0B_0B0B, 8'h11, 8'h40, 16'h0100, 16'd10);
    wait_done(n, to);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || got_q.size() != exp_q.size() || mism != 0) begin
      errors++; $display("FAIL b2b_first: %0d bytes %0d wrong required %0d bytes", got_q.size(), mism, exp_q.size());
    end
    new_frame();
    start_frame(32'h0C0C_0C0C, 32'h0D0D_0D0D, 8'h01, 8'hFF, 16'hFFFF, 16'd7);
    done_cnt = 0;
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: busy %b required 1", tx_busy);
    end
    wait_done(n, to);
    tick(); tick();
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || got_q.size() != exp_q.size() || mism != 0 || done_cnt != 1) begin
      errors++; $display("FAIL b2b_second: %0d bytes %0d wrong done %0d required %0d bytes 1 done", got_q.size(), mism, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, mism, k;
    bit to;
    rand_ready = 1'b0; rand_valid = 1'b0;
    new_frame();
    start_frame(32'h1111_2222, 32'h3333_4444, 8'h11, 8'h40, 16'h5555, 16'd30);
    k = 0;
    while (got_q.size() < 7 && k < 100) begin tick(); k++; end
    checks++;
    if (tx_payload_ipv4 !== 1'b1 || tx_payload !== exp_q[7]) begin
      errors++; $display("FAIL rstmid_pre: valid %b byte %h required 1 %h", tx_payload_ipv4, tx_payload, exp_q[7]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_busy, tx_err, tx_done, tx_data_ready, tx_payload_ipv4} !== 5'b0 || tx_payload !== 8'h00) begin
      errors++; $display("FAIL rstmid_async: flags %b byte %h required 00000 00",
                         {tx_busy, tx_err, tx_done, tx_data_ready, tx_payload_ipv4}, tx_payload);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rand_ready = 1'b1;
    new_frame();
    start_frame(32'h1111_2222, 32'h3333_4444, 8'h11, 8'h40, 16'h5556, 16'd30);
    wait_done(n, to);
    tick(); tick();
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (to || got_q.size() != exp_q.size() || mism != 0 || done_cnt != 1) begin
      errors++; $display("FAIL rstmid_after: %0d bytes %0d wrong done %0d required %0d bytes", got_q.size(), mism, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_random();
    int n, mism;
    bit to;
    logic [15:0] len;
    for (int f = 0; f < 4; f++) begin
      rand_ready = 1'b1; rand_valid = 1'b1;
      len = 16'($urandom_range(0, 64));
      new_frame();
      start_frame($urandom, $urandom, 8'($urandom), 8'($urandom), 16'($urandom), len);
      wait_done(n, to);
      tick(); tick();
      mism = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
      checks++;
      if (to || got_q.size() != exp_q.size() || mism != 0 || done_cnt != 1 || consumed != int'(len)) begin
        errors++; $display("FAIL random_frame%0d: %0d bytes %0d wrong done %0d consumed %0d required %0d bytes len %0d",
                           f, got_q.size(), mism, done_cnt, consumed, exp_q.size(), len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len0();
    test_limits();
    test_start_in_payload();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_ipv4.md
# tx_ipv4

Transmit-side IPv4 framer: accepts header fields plus a payload length from the transport layer (UDP), computes the header checksum, then emits the 20-byte IPv4 header followed by the payload bytes as one octet stream toward the Ethernet TX framer. It sits between the UDP transmitter and the MAC TX path and mirrors the receive-side IPv4 parser.

## Interface
- OCT, 8, octet width; all byte ports are OCT bits.
- MAX_PAYLOAD, 1480, largest accepted payload length in bytes (MTU 1500 − 20).

- TX_CLK  in  1  transmit clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- tx_start  in  1  one-cycle request; header fields are sampled on the same edge.
- tx_src_ip  in  32  source address.
- tx_dst_ip  in  32  destination address.
- tx_protocol  in  8  protocol number (0x11 = UDP).
- tx_ttl  in  8  time to live.
- tx_id  in  16  identification.
- tx_payload_len  in  16  payload byte count (excludes header).
- tx_busy  out  1  high from the accepting edge until the last byte transfers.
- tx_err  out  1  one-cycle pulse when a start is rejected.
- tx_done  out  1  one-cycle pulse after the final byte transfers.
- tx_data_in  in  OCT  upstream payload byte.
- tx_data_valid  in  1  upstream byte valid.
- tx_data_ready  out  1  payload byte accepted this cycle.
- tx_payload_ipv4  out  1  downstream byte valid.
- tx_payload  out  OCT  downstream byte.
- tx_payload_ready  in  1  downstream accepts the byte this cycle.

## Operation
- States: IDLE → CSUM → HEADER → PAYLOAD → IDLE. A byte transfers on any edge where tx_payload_ipv4 && tx_payload_ready.
- IDLE: a tx_start with tx_payload_len ≤ MAX_PAYLOAD latches all fields, clears the accumulator and the byte counter, and moves to CSUM. A tx_start with tx_payload_len > MAX_PAYLOAD pulses tx_err and stays in IDLE. A tx_start outside IDLE is ignored.
- Fixed fields: version 4, IHL 5 (byte 0x45), TOS 0x00, flags/fragment 0x4000 (DF set, offset 0). Total length is tx_payload_len + 20, 16-bit.
- CSUM: adds one 16-bit header word per cycle (10 words, checksum word taken as 0) into a 20-bit accumulator. A final fold cycle adds carries twice into the low 16 bits and inverts the result to give the checksum.
- HEADER: emits bytes 0–19 in network order (MSB first), one per transfer. The byte counter advances only on a transfer, and valid/data hold while ready is low. After byte 19 transfers, the block goes to PAYLOAD, or to IDLE with tx_done if the payload length is 0.
- PAYLOAD: pass-through with tx_payload = tx_data_in, tx_payload_ipv4 = tx_data_valid, tx_data_ready = tx_payload_ready. The block counts transfers; when the count reaches tx_payload_len it returns to IDLE and pulses tx_done. tx_data_ready is low in every other state.
- Upstream bytes beyond tx_payload_len are not consumed.

## Timing
- Reset values: tx_busy 0, tx_err 0, tx_done 0, tx_data_ready 0, tx_payload_ipv4 0, tx_payload 0; state IDLE.
- Start accepted at edge E0 (tx_busy high after E0). Accumulation runs on E1–E10 and the fold on E11. tx_payload_ipv4 rises after E11 with byte 0x45.
- With ready held high, the last header byte transfers at E31. The first payload byte can transfer at E32.
- tx_done is high for the cycle after the last transfer. tx_busy falls on that same edge, and a new tx_start is accepted in that cycle.
- Reset mid-frame: all outputs drop to their reset values immediately (asynchronous). There is no partial-frame recovery.

## Structure
- Package ipv4_pkg holds: state encoding, IPV4_VER_IHL (8'h45), IPV4_FLAGS_DF (16'h4000), IPV4_HDR_LEN (20), and the default MAX_PAYLOAD. The receive parser shares it.
- Sub-module ipv4_csum: a one's-complement word accumulator with clear, add and fold/invert controls, reused later for RX checksum verification.

## Test plan
- Start: src C0A8_0001, dst C0A8_00C7, proto 0x11, ttl 0x40, id 0, len 95. Required header: 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, then 95 payload bytes passed unchanged, then one tx_done pulse.
- Same start with tx_payload_ready toggled pseudo-randomly: the byte sequence is identical, no byte is duplicated or dropped, and tx_payload is stable while ready is low.
- len 0: exactly 20 bytes with total length 0x0014, tx_done after byte 20, and tx_data_ready never asserted.
- len 1481: one tx_err pulse, tx_busy stays 0, no output. len 1480: accepted, total length 0x05DC.
- tx_start pulsed during PAYLOAD: ignored and the frame is unaffected. tx_start in the tx_done cycle: the second frame starts correctly.
- rst_n asserted at header byte 7: outputs are 0 immediately. After release, a new start produces a correct full frame.
